// File: rtl/prim_sum_tree_pkg.sv
// prim_sum_tree_pkg: pipeline depth helpers and per-stage control payload for the pipelined sum tree
package prim_sum_tree_pkg;
  typedef struct packed {
    logic any;
    logic last;
  } stage_ctl_t;
  function automatic int sum_tree_regs(input int num_src, input int reg_every);
    return ($clog2(num_src) + reg_every - 1) / reg_every;
  endfunction
  function automatic int sum_tree_latency(input int num_src, input int reg_every);
    return sum_tree_regs(num_src, reg_every) + 1;
  endfunction
  function automatic int node_width(input int width, input int level);
    return width + level;
  endfunction
endpackage

// File: rtl/prim_sum_tree_slice.sv
// prim_sum_tree_slice: adder levels [Lo,Hi) of the sum tree followed by one pipeline register
module prim_sum_tree_slice
  import prim_sum_tree_pkg::*;
#(
  parameter int Width = 8,
  parameter int NumLevels = 5,
  parameter int Lo = 0,
  parameter int Hi = 2,
  localparam int InN = 2 ** (NumLevels - Lo),
  localparam int OutN = 2 ** (NumLevels - Hi),
  localparam int InW = node_width(Width, Lo),
  localparam int OutW = node_width(Width, Hi)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic                   any_i,
  input  logic                   last_i,
  input  logic [InN*InW-1:0]     data_i,
  output logic                   valid_o,
  output logic                   any_o,
  output logic                   last_o,
  output logic [OutN*OutW-1:0]   data_o
);
  // each level halves the node count and widens by one bit, so no level can overflow
  for (genvar l = 0; l <= Hi - Lo; l++) begin : g_lvl
    localparam int N = InN >> l;
    localparam int W = InW + l;
    logic [N-1:0][W-1:0] node;
    if (l == 0) begin : g_in
      assign node = data_i;
    end else begin : g_add
      for (genvar n = 0; n < N; n++) begin : g_node
        assign node[n] = W'(g_lvl[l-1].node[2*n]) + W'(g_lvl[l-1].node[2*n+1]);
      end
    end
  end
  logic                 valid_q;
  stage_ctl_t           ctl_q;
  logic [OutN*OutW-1:0] data_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      ctl_q   <= '{any: any_i, last: last_i};
      data_q  <= g_lvl[Hi-Lo].node;
    end
  end
  assign valid_o = valid_q;
  assign any_o   = ctl_q.any;
  assign last_o  = ctl_q.last;
  assign data_o  = data_q;
endmodule

// File: rtl/prim_sum_tree_pipe.sv
// prim_sum_tree_pipe: pipelined, stallable masked-sum reduction with packet accumulation and overflow flag
module prim_sum_tree_pipe
  import prim_sum_tree_pkg::*;
#(
  parameter int NumSrc   = 32,
  parameter int Width    = 8,
  parameter int SumWidth = Width + $clog2(NumSrc),
  parameter int RegEvery = 2,
  parameter bit Saturate = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NumSrc-1:0][Width-1:0]   values_i,
  input  logic [NumSrc-1:0]              mask_i,
  input  logic                           last_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [SumWidth-1:0]            sum_o,
  output logic                           sat_o,
  output logic                           any_o
);
  localparam int NumLevels = $clog2(NumSrc);
  localparam int PadSrc    = 2 ** NumLevels;
  localparam int NTreeRegs = sum_tree_regs(NumSrc, RegEvery);
  localparam int TreeW     = node_width(Width, NumLevels);
  localparam int ExtW      = (SumWidth > TreeW ? SumWidth : TreeW) + 1;
  localparam int RefW      = SumWidth + 16;
  logic en;
  logic valid_q, sat_q, any_q, acc_sat_q, acc_any_q;
  logic [SumWidth-1:0] sum_q, acc_q, sum_d;
  logic [PadSrc-1:0][Width-1:0] lanes;
  assign en      = ~valid_q | ready_i;
  assign ready_o = en;
  always_comb begin
    lanes = '0;
    for (int i = 0; i < NumSrc; i++) lanes[i] = mask_i[i] ? values_i[i] : '0;
  end
  for (genvar s = 0; s < NTreeRegs; s++) begin : g_st
    localparam int Lo = s * RegEvery;
    localparam int Hi = (Lo + RegEvery < NumLevels) ? Lo + RegEvery : NumLevels;
    logic in_valid, in_any, in_last, out_valid, out_any, out_last;
    logic [(2 ** (NumLevels - Lo)) * node_width(Width, Lo)-1:0] in_data;
    logic [(2 ** (NumLevels - Hi)) * node_width(Width, Hi)-1:0] out_data;
    if (s == 0) begin : g_src
      assign {in_valid, in_any, in_last, in_data} = {valid_i, |mask_i, last_i, lanes};
    end else begin : g_src
      assign {in_valid, in_any, in_last, in_data} =
        {g_st[s-1].out_valid, g_st[s-1].out_any, g_st[s-1].out_last, g_st[s-1].out_data};
    end
    prim_sum_tree_slice #(
      .Width(Width), .NumLevels(NumLevels), .Lo(Lo), .Hi(Hi)
    ) u_slice (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en),
      .valid_i(in_valid), .any_i(in_any), .last_i(in_last), .data_i(in_data),
      .valid_o(out_valid), .any_o(out_any), .last_o(out_last), .data_o(out_data)
    );
  end
  logic             tree_valid, tree_any, tree_last, ovf, sat_d, any_d;
  logic [TreeW-1:0] tree_sum;
  logic [ExtW-1:0]  total;
  assign tree_valid = g_st[NTreeRegs-1].out_valid;
  assign tree_any   = g_st[NTreeRegs-1].out_any;
  assign tree_last  = g_st[NTreeRegs-1].out_last;
  assign tree_sum   = g_st[NTreeRegs-1].out_data;
  // widened add catches both a carry out and a tree sum too wide for the accumulator
  assign total = ExtW'(acc_q) + ExtW'(tree_sum);
  assign ovf   = |total[ExtW-1:SumWidth];
  assign sat_d = acc_sat_q | ovf;
  assign any_d = acc_any_q | tree_any;
  assign sum_d = (Saturate && sat_d) ? '1 : total[SumWidth-1:0];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      sum_q     <= '0;
      sat_q     <= 1'b0;
      any_q     <= 1'b0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      acc_any_q <= 1'b0;
    end else if (en) begin
      valid_q <= tree_valid & tree_last;
      if (tree_valid & tree_last) begin
        sum_q <= sum_d;
        sat_q <= sat_d;
        any_q <= any_d;
      end
      if (tree_valid) begin
        acc_q     <= tree_last ? '0 : sum_d;
        acc_sat_q <= ~tree_last & sat_d;
        acc_any_q <= ~tree_last & any_d;
      end
    end
  end
  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign sat_o   = sat_q;
  assign any_o   = any_q;
  // exact reference sum taken straight from the inputs, delayed alongside the tree
  logic [TreeW-1:0] ref_beat;
  logic [TreeW-1:0] ref_pipe_q [NTreeRegs];
  logic [RefW-1:0]  ref_acc_q, ref_out_q, ref_tot;
  always_comb begin
    ref_beat = '0;
    for (int i = 0; i < NumSrc; i++) ref_beat = ref_beat + (mask_i[i] ? TreeW'(values_i[i]) : '0);
  end
  assign ref_tot = ref_acc_q + RefW'(ref_pipe_q[NTreeRegs-1]);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTreeRegs; i++) ref_pipe_q[i] <= '0;
      ref_acc_q <= '0;
      ref_out_q <= '0;
    end else if (en) begin
      ref_pipe_q[0] <= ref_beat;
      for (int i = 1; i < NTreeRegs; i++) ref_pipe_q[i] <= ref_pipe_q[i-1];
      if (tree_valid) begin
        ref_acc_q <= tree_last ? '0 : ref_tot;
        if (tree_last) ref_out_q <= ref_tot;
      end
    end
  end
  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_q && !ready_i |=> valid_q && $stable(sum_q) && $stable(sat_q) && $stable(any_q));
  a_no_ovf_exact: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_q && (ref_out_q >> SumWidth) == '0 |-> !sat_q && RefW'(sum_q) == ref_out_q);
  a_nosat_exact: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_q && !sat_q |-> RefW'(sum_q) == ref_out_q);
endmodule

// File: tb/tb_prim_sum_tree_pipe.sv
// tb_prim_sum_tree_pipe: directed scoreboard bench driving a wide, a saturating and a wrapping 8-bit instance in lockstep
module tb_prim_sum_tree_pipe;
  typedef struct {int unsigned sum; logic sat; logic any;} exp_t;
  logic clk = 0, rst = 1, valid_i = 0, last_i = 0, ready_i = 1;
  logic [31:0][7:0] values_i = '0;
  logic [31:0] mask_i = '0;
  logic rdy_m, rdy_s, rdy_w, vo_m, vo_s, vo_w, sat_m, sat_s, sat_w, any_m, any_s, any_w;
  logic [12:0] sum_m;
  logic [7:0] sum_s, sum_w;
  exp_t q_m[$], q_s[$], q_w[$];
  int checks = 0, errors = 0, lat;
  int unsigned pkt_sum = 0;
  logic pkt_any = 0;
  logic stall_q = 0;
  logic [15:0] hold_q = '0;
  always #5 clk = ~clk;
  prim_sum_tree_pipe u_main (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_m), .values_i(values_i),
    .mask_i(mask_i), .last_i(last_i), .valid_o(vo_m), .ready_i(ready_i),
    .sum_o(sum_m), .sat_o(sat_m), .any_o(any_m));
  prim_sum_tree_pipe #(.SumWidth(8), .Saturate(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_s), .values_i(values_i),
    .mask_i(mask_i), .last_i(last_i), .valid_o(vo_s), .ready_i(ready_i),
    .sum_o(sum_s), .sat_o(sat_s), .any_o(any_s));
  prim_sum_tree_pipe #(.SumWidth(8), .Saturate(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy_w), .values_i(values_i),
    .mask_i(mask_i), .last_i(last_i), .valid_o(vo_w), .ready_i(ready_i),
    .sum_o(sum_w), .sat_o(sat_w), .any_o(any_w));
  task automatic check_out(input string nm, input int unsigned s, input logic st, input logic a, input exp_t e);
    checks++;
    if (s !== e.sum || st !== e.sat || a !== e.any) begin
      errors++;
      $display("FAIL %s: got sum=%0d sat=%0b any=%0b, want sum=%0d sat=%0b any=%0b", nm, s, st, a, e.sum, e.sat, e.any);
    end
  endtask
  task automatic check_bit(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask
  task automatic beat(input logic [7:0] v, input logic [31:0] m, input logic l);
    int n = 0;
    @(negedge clk);
    valid_i = 1;
    last_i = l;
    mask_i = m;
    for (int i = 0; i < 32; i++) values_i[i] = v;
    #1;
    while (!rdy_m && n < 50) begin @(negedge clk); #1; n++; end
    if (!rdy_m) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: ready_o stayed 0 for %0d cycles, want 1", n);
    end else begin
      @(posedge clk);
      pkt_sum += int'(v) * $countones(m);
      pkt_any |= |m;
      if (l) begin
        q_m.push_back('{pkt_sum, 1'b0, pkt_any});
        q_s.push_back('{(pkt_sum > 255) ? 255 : pkt_sum, pkt_sum > 255, pkt_any});
        q_w.push_back('{pkt_sum % 256, pkt_sum > 255, pkt_any});
        pkt_sum = 0;
        pkt_any = 0;
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 0;
      last_i = 0;
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst && vo_m && ready_i) begin
      if (q_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL main_extra: got output sum=%0d, want none", sum_m);
      end else check_out("main_out", sum_m, sat_m, any_m, q_m.pop_front());
    end
    if (!rst && stall_q) begin
      checks++;
      if ({vo_m, sum_m, sat_m, any_m} !== hold_q) begin
        errors++;
        $display("FAIL stall_hold: got %h, want %h", {vo_m, sum_m, sat_m, any_m}, hold_q);
      end
    end
    if (!rst && vo_m && !ready_i) check_bit("ready_stall", rdy_m, 1'b0);
    stall_q = !rst && vo_m && !ready_i;
    hold_q = {vo_m, sum_m, sat_m, any_m};
  end
  always @(negedge clk) begin
    #2;
    if (!rst && vo_s && ready_i) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_extra: got output sum=%0d, want none", sum_s);
      end else check_out("sat_out", sum_s, sat_s, any_s, q_s.pop_front());
    end
  end
  always @(negedge clk) begin
    #2;
    if (!rst && vo_w && ready_i) begin
      if (q_w.size() == 0) begin
        checks++; errors++;
        $display("FAIL wrap_extra: got output sum=%0d, want none", sum_w);
      end else check_out("wrap_out", sum_w, sat_w, any_w, q_w.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check_bit("rst_valid", vo_m, 1'b0);
    check_bit("rst_ready", rdy_m, 1'b1);
    check_bit("rst_sat", sat_m, 1'b0);
    check_bit("rst_any", any_m, 1'b0);
    check_bit("rst_sum_zero", sum_m == '0, 1'b1);
    beat(8'hFF, '1, 1'b1);
    @(negedge clk);
    valid_i = 0;
    lat = 1;
    while (!vo_m && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL latency: got %0d cycles, want 4", lat); end
    idle(2);
    beat(8'h55, '0, 1'b1);
    idle(2);
    beat(8'd10, 32'h1, 1'b0);
    beat(8'd20, 32'h1, 1'b0);
    beat(8'd30, 32'h1, 1'b1);
    idle(2);
    beat(8'd100, 32'h3, 1'b0);
    beat(8'd100, 32'h3, 1'b1);
    beat(8'd5, 32'h1, 1'b1);
    idle(6);
    fork
      for (int k = 1; k <= 8; k++) beat(8'(k), 32'hF, 1'b1);
      begin
        repeat (5) @(negedge clk);
        ready_i = 0;
        repeat (6) @(negedge clk);
        ready_i = 1;
      end
    join
    idle(10);
    beat(8'd9, 32'h1, 1'b0);
    beat(8'd9, 32'h1, 1'b0);
    idle(6);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    check_bit("rst_mid_valid", vo_m, 1'b0);
    rst = 0;
    pkt_sum = 0;
    pkt_any = 0;
    beat(8'd7, 32'h1, 1'b1);
    idle(12);
    checks++;
    if (q_m.size() + q_s.size() + q_w.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: got %0d unconsumed results, want 0", q_m.size() + q_s.size() + q_w.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
